// File: rtl/rcc_ker_clk_div_gate.sv
// Multi-channel kernel clock enable generator: per-channel divider,
// period-aligned gate-off and a req/ack ratio-update handshake.
module rcc_ker_clk_div_gate #(
  parameter int NUM_CH  = 4,
  parameter int NUM_CPU = 2,
  parameter int DIV_W   = 5,
  parameter int RST_DIV = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      testmode,
  input  logic [NUM_CPU-1:0]        cpu_sleep,
  input  logic [NUM_CPU-1:0]        cpu_deepsleep,
  input  logic                      d3_deepsleep,
  input  logic [NUM_CH*NUM_CPU-1:0] ch_en,
  input  logic [NUM_CH*NUM_CPU-1:0] ch_lpen,
  input  logic [NUM_CH-1:0]         ch_amen,
  input  logic [NUM_CH*DIV_W-1:0]   div_ratio,
  input  logic [NUM_CH-1:0]         div_upd_req,
  output logic [NUM_CH-1:0]         div_upd_ack,
  output logic [NUM_CH-1:0]         ker_clk_en,
  output logic [NUM_CH-1:0]         ch_busy
);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           state;
    state_t           state_nx;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nx;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] ratio_q;
    logic [DIV_W-1:0] ratio_nx;
    logic [DIV_W-1:0] r;
    logic             ack_q;
    logic             tc;
    logic             active;
    logic             load;
    logic             req_on;

    always_comb begin
      req_on = ch_amen[c] & ~d3_deepsleep;
      for (int i = 0; i < NUM_CPU; i++) begin
        req_on = req_on
               | (ch_en[c*NUM_CPU+i]
                  & (~cpu_sleep[i] | ch_lpen[c*NUM_CPU+i])
                  & ~cpu_deepsleep[i]);
      end
    end

    // A programmed ratio of zero behaves as divide-by-one.
    assign r       = (ratio_q == '0) ? DIV_W'(1) : ratio_q;
    assign tc      = (cnt == r - DIV_W'(1));
    assign cnt_inc = tc ? '0 : cnt + DIV_W'(1);
    assign active  = (state != OFF);
    assign load    = div_upd_req[c] & ~ack_q & (~active | tc);

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      ratio_nx = ratio_q;
      unique case (state)
        OFF: begin
          if (req_on) begin
            state_nx = RUN;
            cnt_nx   = '0;
          end
        end
        RUN: begin
          cnt_nx = cnt_inc;
          if (!req_on) state_nx = tc ? OFF : STOP;
        end
        STOP: begin
          cnt_nx = cnt_inc;
          if (req_on)  state_nx = RUN;
          else if (tc) state_nx = OFF;
        end
        default: begin
          state_nx = OFF;
          cnt_nx   = '0;
        end
      endcase
      // Loads only land on a period boundary, so the new ratio
      // always starts with a fresh count.
      if (load) begin
        ratio_nx = div_ratio[c*DIV_W +: DIV_W];
        cnt_nx   = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= OFF;
        cnt     <= '0;
        ratio_q <= DIV_W'(RST_DIV);
        ack_q   <= 1'b0;
      end else begin
        state   <= state_nx;
        cnt     <= cnt_nx;
        ratio_q <= ratio_nx;
        ack_q   <= load;
      end
    end

    assign div_upd_ack[c] = ack_q;
    assign ker_clk_en[c]  = testmode | (active & tc);
    assign ch_busy[c]     = active;
  end

endmodule

// File: tb/tb_rcc_ker_clk_div_gate.sv
// Bench for rcc_ker_clk_div_gate: expectations queued per cycle and
// checked on the falling edge, plus a req_on truth table on ch3.
module tb_rcc_ker_clk_div_gate;
  localparam int NCH  = 4;
  localparam int NCPU = 2;
  localparam int DW   = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 testmode = 1'b0;
  logic [NCPU-1:0]      cpu_sleep = '0;
  logic [NCPU-1:0]      cpu_deepsleep = '0;
  logic                 d3_deepsleep = 1'b0;
  logic [NCH*NCPU-1:0]  ch_en = '0;
  logic [NCH*NCPU-1:0]  ch_lpen = '0;
  logic [NCH-1:0]       ch_amen = '0;
  logic [NCH*DW-1:0]    div_ratio = '0;
  logic [NCH-1:0]       div_upd_req = '0;
  logic [NCH-1:0]       div_upd_ack;
  logic [NCH-1:0]       ker_clk_en;
  logic [NCH-1:0]       ch_busy;

  rcc_ker_clk_div_gate #(
    .NUM_CH(NCH), .NUM_CPU(NCPU), .DIV_W(DW), .RST_DIV(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .testmode(testmode),
    .cpu_sleep(cpu_sleep),
    .cpu_deepsleep(cpu_deepsleep),
    .d3_deepsleep(d3_deepsleep),
    .ch_en(ch_en),
    .ch_lpen(ch_lpen),
    .ch_amen(ch_amen),
    .div_ratio(div_ratio),
    .div_upd_req(div_upd_req),
    .div_upd_ack(div_upd_ack),
    .ker_clk_en(ker_clk_en),
    .ch_busy(ch_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    ch;
    logic  en;
    logic  busy;
    logic  ack;
  } exp_t;

  typedef struct {
    logic [1:0] en;
    logic [1:0] lpen;
    logic [1:0] slp;
    logic [1:0] dsl;
    logic       amen;
    logic       d3;
    logic       exp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string nm, input int c,
                      input logic en, input logic busy,
                      input logic ack);
    exp_t e;
    e.nm = nm; e.ch = c; e.en = en; e.busy = busy; e.ack = ack;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ratio(input int c, input logic [DW-1:0] v);
    div_ratio[c*DW +: DW] = v;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    logic [2:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = {ker_clk_en[e.ch], ch_busy[e.ch], div_upd_ack[e.ch]};
      n_cmp++;
      if (got !== {e.en, e.busy, e.ack}) begin
        n_bad++;
        $display("FAIL %s ch%0d: en/busy/ack got %b want %b%b%b",
                 e.nm, e.ch, got, e.en, e.busy, e.ack);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2'b10, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{2'b11, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{2'b11, 2'b01, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};

    // reset state
    #3;
    for (int c = 0; c < NCH; c++) push("rst", c, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // ch0, ratio 1: continuous strobe one cycle after enable
    ch_en[0] = 1'b1;
    push("t1_idle", 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      push("t1_cont", 0, 1, 1, 0);
      tick();
    end

    // ch1: load ratio 4 while OFF, req held through the ack cycle
    set_ratio(1, 5'd4);
    div_upd_req[1] = 1'b1;
    push("t2_req", 1, 0, 0, 0);
    tick();
    push("t2_ack", 1, 0, 0, 1);
    tick();
    div_upd_req[1] = 1'b0;
    ch_amen[1] = 1'b1;
    push("t2_noack", 1, 0, 0, 0);
    tick();
    for (int k = 1; k <= 8; k++) begin
      push("t2_div4", 1, (k % 4 == 0), 1, 0);
      tick();
    end

    // ch2 ratio 5: stop at cnt=1, drains to the period end
    set_ratio(2, 5'd5);
    div_upd_req[2] = 1'b1;
    push("t3_req", 2, 0, 0, 0);
    tick();
    div_upd_req[2] = 1'b0;
    push("t3_ack", 2, 0, 0, 1);
    tick();
    ch_en[4] = 1'b1;
    push("t3_idle", 2, 0, 0, 0);
    tick();
    push("t3_c0", 2, 0, 1, 0);
    tick();
    ch_en[4] = 1'b0;
    push("t3_c1", 2, 0, 1, 0);
    tick();
    push("t3_stop2", 2, 0, 1, 0);
    tick();
    push("t3_stop3", 2, 0, 1, 0);
    tick();
    push("t3_stop_tc", 2, 1, 1, 0);
    tick();
    push("t3_off", 2, 0, 0, 0);
    tick();
    push("t3_off2", 2, 0, 0, 0);
    tick();
    // resume from STOP at cnt=3 keeps cadence
    ch_en[4] = 1'b1;
    push("t3_re_idle", 2, 0, 0, 0);
    tick();
    push("t3_re_c0", 2, 0, 1, 0);
    tick();
    ch_en[4] = 1'b0;
    push("t3_re_c1", 2, 0, 1, 0);
    tick();
    push("t3_re_stop2", 2, 0, 1, 0);
    tick();
    ch_en[4] = 1'b1;
    push("t3_re_stop3", 2, 0, 1, 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k == 5) ch_en[4] = 1'b0;
      push("t3_resume", 2, (k == 0 || k == 5), 1, 0);
      tick();
    end
    push("t3_tc_drop", 2, 0, 0, 0);
    tick();

    // ch0: 1 -> 3 -> 6, new ratio only from the next period
    set_ratio(0, 5'd3);
    div_upd_req[0] = 1'b1;
    push("t4_req3", 0, 1, 1, 0);
    tick();
    div_upd_req[0] = 1'b0;
    push("t4_ack3", 0, 0, 1, 1);
    tick();
    push("t4_r3_c1", 0, 0, 1, 0);
    tick();
    push("t4_r3_tc", 0, 1, 1, 0);
    tick();
    set_ratio(0, 5'd6);
    div_upd_req[0] = 1'b1;
    push("t4_req6_c0", 0, 0, 1, 0);
    tick();
    push("t4_req6_c1", 0, 0, 1, 0);
    tick();
    push("t4_old_tc", 0, 1, 1, 0);
    tick();
    push("t4_ack6", 0, 0, 1, 1);
    tick();
    push("t4_held", 0, 0, 1, 0);
    tick();
    for (int k = 8; k <= 17; k++) begin
      div_upd_req[0] = 1'b0;
      push("t4_div6", 0, (k == 11 || k == 17), 1, 0);
      tick();
    end

    // drain everything to OFF
    ch_en = '0;
    ch_amen = '0;
    begin
      int w;
      w = 0;
      while (ch_busy != '0 && w < 20) begin
        tick();
        w++;
      end
    end
    n_cmp++;
    if (ch_busy != '0) begin
      n_bad++;
      $display("FAIL drain: ch_busy got %b want 0000", ch_busy);
    end

    // req_on truth table on ch3 (ratio 1)
    for (int v = 0; v < 12; v++) begin
      ch_en[7:6]    = tbl[v].en;
      ch_lpen[7:6]  = tbl[v].lpen;
      cpu_sleep     = tbl[v].slp;
      cpu_deepsleep = tbl[v].dsl;
      ch_amen[3]    = tbl[v].amen;
      d3_deepsleep  = tbl[v].d3;
      tick();
      push($sformatf("t5_vec%0d", v), 3, tbl[v].exp, tbl[v].exp, 0);
    end
    ch_en = '0;
    ch_lpen = '0;
    cpu_sleep = '0;
    cpu_deepsleep = '0;
    ch_amen = '0;
    d3_deepsleep = 1'b0;
    tick();

    // testmode forces strobes on idle channels
    testmode = 1'b1;
    for (int c = 0; c < NCH; c++) push("t6_tm", c, 1, 0, 0);
    tick();
    testmode = 1'b0;
    for (int c = 0; c < NCH; c++) push("t6_tm_off", c, 0, 0, 0);
    tick();

    // async reset mid-period, ratio returns to 1, pending req re-acked
    ch_amen[1] = 1'b1;
    push("t7_idle", 1, 0, 0, 0);
    tick();
    push("t7_c0", 1, 0, 1, 0);
    tick();
    set_ratio(3, 5'd2);
    div_upd_req[3] = 1'b1;
    push("t7_c1", 1, 0, 1, 0);
    push("t7_req", 3, 0, 0, 0);
    tick();
    push("t7_rst_c1", 1, 0, 0, 0);
    push("t7_rst_ack", 3, 0, 0, 0);
    #2 rst_n = 1'b0;
    tick();
    for (int c = 0; c < NCH; c++) push("t7_rst", c, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    push("t7_rel", 1, 0, 0, 0);
    push("t7_rel_req", 3, 0, 0, 0);
    tick();
    div_upd_req[3] = 1'b0;
    push("t7_r1", 1, 1, 1, 0);
    push("t7_reack", 3, 0, 0, 1);
    tick();
    push("t7_r1b", 1, 1, 1, 0);
    push("t7_ack_done", 3, 0, 0, 0);
    tick();
    tick();

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rcc_ker_clk_div_gate.md
Name: rcc_ker_clk_div_gate

Overview:
- Parametrised multi-channel kernel clock enable generator. Generalises the single-peripheral ETH gating to NUM_CH kernels and NUM_CPU cores.
- Adds a per-channel programmable divider, period-aligned gate-off and a req/ack ratio-update handshake.
- Outputs one-cycle enable strobes that drive downstream ICG cells. The block sits in the RCC kernel clock tree, one instance per kernel source clock.

Parameters:
- NUM_CH, 4, number of kernel channels.
- NUM_CPU, 2, number of cores contributing enable/low-power requests.
- DIV_W, 5, divider ratio width; valid ratios 1..2^DIV_W-1, and 0 is treated as 1.
- RST_DIV, 1, divider ratio loaded at reset.

Ports:
- clk  input  1  kernel source clock
- rst_n  input  1  asynchronous active-low reset; all state is reset on assertion, release is synchronous to clk
- testmode  input  1  forces all ker_clk_en high
- cpu_sleep  input  NUM_CPU  per-core sleep
- cpu_deepsleep  input  NUM_CPU  per-core deepsleep
- d3_deepsleep  input  1  D3 domain deepsleep
- ch_en  input  NUM_CH*NUM_CPU  run enable, bit [c*NUM_CPU+i] = channel c, core i
- ch_lpen  input  NUM_CH*NUM_CPU  sleep-mode enable, same packing as ch_en
- ch_amen  input  NUM_CH  autonomous-mode enable per channel
- div_ratio  input  NUM_CH*DIV_W  requested ratio, field [c*DIV_W +: DIV_W]
- div_upd_req  input  NUM_CH  level request to load div_ratio
- div_upd_ack  output  NUM_CH  one-cycle load acknowledge
- ker_clk_en  output  NUM_CH  divided clock-enable strobe
- ch_busy  output  NUM_CH  channel FSM not in OFF

Behaviour:
- Per-channel request, combinational:
  - req_on[c] = OR over i of (ch_en & (~cpu_sleep[i] | ch_lpen) & ~cpu_deepsleep[i]), OR (ch_amen[c] & ~d3_deepsleep).
- Per-channel registers: state {OFF, RUN, STOP}, cnt[DIV_W], ratio_q[DIV_W], ack_q.
  - Effective ratio r = (ratio_q==0) ? 1 : ratio_q.
  - Terminal tc = (cnt == r-1).
- Reset values: state OFF, cnt 0, ratio_q RST_DIV, div_upd_ack 0, ker_clk_en 0 (testmode=0), ch_busy 0.
- FSM transitions:
  - OFF -> RUN when req_on=1; cnt is cleared to 0.
  - RUN -> STOP when req_on=0 and not tc.
  - RUN -> OFF when req_on=0 and tc.
  - STOP -> RUN when req_on=1; cnt is not reset.
  - STOP -> OFF at tc.
  - RUN stays in RUN while req_on=1.
- Counter:
  - In RUN and STOP, cnt increments each cycle and wraps to 0 at tc.
  - In OFF, cnt holds 0.
- ker_clk_en = testmode | ((state==RUN | state==STOP) & tc). It decodes registers only; there is no combinational path from req_on.
- Latency: req_on rising in cycle t gives the first strobe in cycle t+r, then a strobe every r cycles. With r=1 the strobe is continuous from t+1.
- Gate-off is always period-aligned: the last strobe is the terminal cycle of the period in progress, and there is never a truncated period. If req_on drops on the tc cycle itself, that strobe still fires and state is OFF next cycle.
- Ratio update:
  - Load condition: div_upd_req & ~ack_q & (state==OFF | tc).
  - At that edge: ratio_q <= div_ratio and cnt <= 0. ack_q is high for exactly the following cycle.
  - A request still high during the ack cycle is ignored; the requester drops req on seeing ack, and div_ratio must be stable while req is high.
  - In RUN the new ratio takes effect from the next period. The period in which the load happened completes at the old ratio.
- Simultaneous events:
  - Ratio load plus RUN->OFF on the same tc: both happen.
  - Ratio load plus OFF->RUN: the new ratio is used for the first period.
- testmode only overrides the outputs; the FSM and handshake keep operating.
- Reset asserted mid-operation: immediate return to reset values. A pending req is re-acked after release if still high.
- Channels are fully independent; there is no shared state.

Test Plan:
- Reset, RST_DIV=1, core0 ch_en[0]=1 at t=10 -> ch_busy[0] at t=11, ker_clk_en[0]=1 every cycle from t=11.
- Load ratio 4 on ch1 while OFF, then enable via ch_amen[1] with d3_deepsleep=0 -> ack one cycle after req; strobes every 4th cycle, the first 4 cycles after enable.
- ch2 ratio 5 running; drop ch_en when cnt=1 -> state STOP, one more strobe at cnt=4, then OFF, no further strobes. Re-enable at cnt=3 in STOP -> RUN with cadence unbroken.
- ch0 ratio 3 running; request ratio 6 when cnt=0 -> load at next tc; strobe spacing 3, then 6 thereafter; ack exactly 1 cycle; req held 2 extra cycles yields no second ack.
- Sleep matrix: cpu_sleep[1]=1 with ch_lpen=0 -> gates off at period end; ch_lpen=1 -> keeps running; cpu_deepsleep[1]=1 -> off regardless of ch_lpen.
- testmode=1 with all channels OFF -> ker_clk_en all 1. rst_n pulsed low mid-period -> outputs 0 and ratio back to RST_DIV asynchronously.
